nios_cpu_key_input: RTL



---
 rtl/nios_cpu_key_input.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/nios_cpu_key_input.sv
`default_nettype none
// ============================================================================
// Module   : nios_cpu_key_input
// Purpose  : Avalon-MM input PIO: synchronize, debounce and edge-capture
//            external keys/switches, with a masked level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module nios_cpu_key_input #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int c_cnt_w = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_addr_data = 2'd0;
    localparam logic [1:0] c_addr_mask = 2'd2;
    localparam logic [1:0] c_addr_ecap = 2'd3;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [31:0]      r_readdata;

    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd_mux;
    logic             w_wr;

    // Two-flop synchronizer on the raw asynchronous inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit debounce: a change is accepted only after it has persisted
    // for DEBOUNCE_CYCLES consecutive edges against the stable value.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [c_cnt_w-1:0] r_cnt;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt <= '0;
            end else if (r_sync2[i] == r_stable[i]) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_load[i] = (r_sync2[i] != r_stable[i]) && (r_cnt == c_cnt_last);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= '0;
            r_prev   <= '0;
        end else begin
            r_stable <= r_stable ^ w_load;
            r_prev   <= r_stable;
        end
    end

    assign w_rise = r_stable & ~r_prev;
    assign w_fall = ~r_stable & r_prev;

    if (EDGE_TYPE == 0) begin : g_edge_rise
        assign w_edge = w_rise;
    end else if (EDGE_TYPE == 1) begin : g_edge_fall
        assign w_edge = w_fall;
    end else begin : g_edge_any
        assign w_edge = w_rise | w_fall;
    end

    assign w_wr    = chipselect && !write_n;
    assign w_wdata = writedata[WIDTH-1:0];
    assign w_clr   = (w_wr && (address == c_addr_ecap)) ? w_wdata : '0;

    if (WIDTH < 32) begin : g_wdata_upper
        logic w_unused_wdata;
        assign w_unused_wdata = &{1'b0, writedata[31:WIDTH]};
    end

    // A capture arriving on the same edge as its W1C clear is kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask <= '0;
            r_edge_cap <= '0;
        end else begin
            if (w_wr && (address == c_addr_mask)) begin
                r_irq_mask <= w_wdata;
            end
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            c_addr_data: w_rd_mux[WIDTH-1:0] = r_stable;
            c_addr_mask: w_rd_mux[WIDTH-1:0] = r_irq_mask;
            c_addr_ecap: w_rd_mux[WIDTH-1:0] = r_edge_cap;
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge_cap & r_irq_mask);

endmodule
`default_nettype wire
